// File: rtl/act_core_pwl.sv
// act_core_pwl: streaming INT-N activation engine (ReLU, clamped ReLU, LeakyReLU, 8-segment PWL).
// Shadow CSRs are copied to the active set at job start; a 2-stage valid/ready pipeline does the math.
module act_core_pwl #(
  parameter int         DATA_WIDTH = 8,
  parameter int         LANES      = 16,
  parameter int         FRAC       = 4,
  parameter logic [5:0] CFG_BASE   = 6'h30
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          start,
  input  logic                          cfg_wr_en,
  input  logic [5:0]                    cfg_addr,
  input  logic [63:0]                   cfg_wdata,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [LANES-1:0]              in_keep,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_keep,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);

  // state   | meaning
  // ST_IDLE | no job; in_ready low, start copies shadows into the active set
  // ST_BUSY | job running; ends on the handshake of the out_last beat

  localparam int DW   = DATA_WIDTH;
  localparam int BW   = LANES * DATA_WIDTH;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));
  localparam logic [DW-1:0] POS_MAX   = {1'b0, {(DW - 1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN   = {1'b1, {(DW - 1){1'b0}}};
  localparam logic [15:0]   SLOPE_ONE = 16'(1 << FRAC);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e state_q, state_d;
  logic   load_act;

  logic [2:0]             mode_sh_q, mode_q;
  logic [3:0]             leaky_sh_q, leaky_q;
  logic signed [DW-1:0]   clamp_sh_q, clamp_q;
  logic signed [15:0]     slope_sh_q [8];
  logic signed [15:0]     offset_sh_q [8];
  logic signed [15:0]     slope_q [8];
  logic signed [15:0]     offset_q [8];

  logic [6:0] cfg_off;
  logic [2:0] cfg_seg;
  logic       unused_wdata;

  logic                   s1_valid_q;
  logic [BW-1:0]          s1_data_q;
  logic [LANES-1:0]       s1_keep_q;
  logic                   s1_last_q;
  logic signed [31:0]     s1_prod_q [LANES];
  logic signed [31:0]     prod_d [LANES];

  logic                   out_valid_q;
  logic [BW-1:0]          out_data_q;
  logic [LANES-1:0]       out_keep_q;
  logic                   out_last_q;
  logic [BW-1:0]          y_d;

  logic s2_adv, s1_adv, accept;

  // Widened subtraction so addresses below CFG_BASE never alias into the window.
  assign cfg_off      = {1'b0, cfg_addr} - {1'b0, CFG_BASE};
  assign cfg_seg      = cfg_off[2:0] - 3'd1;
  assign unused_wdata = ^cfg_wdata[63:32];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mode_sh_q  <= '0;
      leaky_sh_q <= '0;
      clamp_sh_q <= POS_MAX;
      for (int s = 0; s < 8; s++) begin
        slope_sh_q[s]  <= SLOPE_ONE;
        offset_sh_q[s] <= '0;
      end
    end else if (cfg_wr_en) begin
      if (cfg_off == 7'd0) begin
        mode_sh_q  <= cfg_wdata[2:0];
        leaky_sh_q <= cfg_wdata[11:8];
        clamp_sh_q <= cfg_wdata[16 +: DW];
      end else if (cfg_off <= 7'd8) begin
        slope_sh_q[cfg_seg]  <= cfg_wdata[15:0];
        offset_sh_q[cfg_seg] <= cfg_wdata[31:16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mode_q  <= '0;
      leaky_q <= '0;
      clamp_q <= POS_MAX;
      for (int s = 0; s < 8; s++) begin
        slope_q[s]  <= SLOPE_ONE;
        offset_q[s] <= '0;
      end
    end else if (load_act) begin
      mode_q   <= mode_sh_q;
      leaky_q  <= leaky_sh_q;
      clamp_q  <= clamp_sh_q;
      slope_q  <= slope_sh_q;
      offset_q <= offset_sh_q;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_act = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_BUSY;
          load_act = 1'b1;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (out_valid_q && out_ready && out_last_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = busy && s1_adv;
  assign accept   = in_valid && in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DW-1:0] x_in, x1, y;
    logic [2:0]           seg_in, seg1;
    logic signed [31:0]   pwl_t;

    assign x_in   = in_data[l*DW +: DW];
    assign seg_in = in_data[l*DW + DW - 1 -: 3];
    assign prod_d[l] = 32'(x_in) * 32'(slope_q[seg_in]);

    assign x1    = s1_data_q[l*DW +: DW];
    assign seg1  = s1_data_q[l*DW + DW - 1 -: 3];
    assign pwl_t = (s1_prod_q[l] >>> FRAC) + 32'(offset_q[seg1]);

    always_comb begin
      y = '0;
      if (s1_keep_q[l]) begin
        case (mode_q)
          3'd0: y = x1[DW-1] ? '0 : x1;
          3'd1: begin
            // A negative ceiling clamps everything to zero rather than going negative.
            if (clamp_q[DW-1] || x1[DW-1]) y = '0;
            else if (x1 > clamp_q)         y = clamp_q;
            else                           y = x1;
          end
          3'd2: y = x1[DW-1] ? (x1 >>> leaky_q) : x1;
          3'd3: begin
            if (pwl_t > MAXV)      y = POS_MAX;
            else if (pwl_t < MINV) y = NEG_MIN;
            else                   y = pwl_t[DW-1:0];
          end
          default: y = x1;
        endcase
      end
    end

    assign y_d[l*DW +: DW] = y;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_keep_q  <= '0;
      s1_last_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) s1_prod_q[l] <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q <= in_data;
        s1_keep_q <= in_keep;
        s1_last_q <= in_last;
        s1_prod_q <= prod_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= y_d;
        out_keep_q <= s1_keep_q;
        out_last_q <= s1_last_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_act_core_pwl.sv
// tb_act_core_pwl: table-driven single-beat jobs per activation mode, plus hand-written
// backpressure, shadow-isolation and async-reset sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_act_core_pwl;
  localparam int DW = 8;
  localparam int LN = 16;
  localparam int BW = DW * LN;
  localparam logic [5:0] BASE = 6'h30;

  logic clk = 1'b0;
  logic rst_b, start, cfg_wr_en, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, busy, done;
  logic [5:0]    cfg_addr;
  logic [63:0]   cfg_wdata;
  logic [BW-1:0] in_data, out_data;
  logic [LN-1:0] in_keep, out_keep;

  always #5 clk = ~clk;

  act_core_pwl dut (
    .clk(clk), .rst_b(rst_b), .start(start),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [2:0]        mode;
    logic [3:0]        leaky;
    logic [7:0]        clamp;
    logic [15:0]       slope3;
    logic [15:0]       keep;
    logic [0:7][7:0]   x;
    logic [0:7][7:0]   e;
  } rec_t;

  typedef struct packed {
    logic [BW-1:0] d;
    logic [LN-1:0] k;
    logic          l;
  } beat_t;

  rec_t  tbl [8];
  beat_t sb [$];
  int errors = 0, checks = 0;
  int done_cnt = 0, acc_cnt = 0, dlv_cnt = 0;
  logic chk_rdy = 1'b0, stall_seen = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [0:7][7:0] v8(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
    logic [0:7][7:0] r;
    r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0]; r[3] = a3[7:0];
    r[4] = a4[7:0]; r[5] = a5[7:0]; r[6] = a6[7:0]; r[7] = a7[7:0];
    return r;
  endfunction

  function automatic rec_t mk(int m, int sh, int cl, int s3, int k, logic [0:7][7:0] x, logic [0:7][7:0] e);
    rec_t r;
    r.mode = m[2:0]; r.leaky = sh[3:0]; r.clamp = cl[7:0];
    r.slope3 = s3[15:0]; r.keep = k[15:0]; r.x = x; r.e = e;
    return r;
  endfunction

  function automatic logic [BW-1:0] lanes_of(logic [0:7][7:0] v, logic [LN-1:0] k);
    logic [BW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = k[i] ? v[i % 8] : 8'h00;
    return r;
  endfunction

  function automatic logic [BW-1:0] bp_data(int b);
    logic [BW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = 8'(b * 53 + i * 29 + 7);
    return r;
  endfunction

  function automatic logic [63:0] cfg_word(logic [2:0] m, logic [3:0] sh, logic [7:0] cl);
    return {32'h0, 8'h0, cl, 4'h0, sh, 5'h0, m};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [5:0] a, input logic [63:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic [LN-1:0] k, input logic l, input logic [BW-1:0] e);
    int n = 0;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("accept");
    else sb.push_back({e, k, l});
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail("job_end");
    @(posedge clk); #1;
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin : monitor
    beat_t b, held;
    logic  stall_q;
    stall_q = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        stall_q = 1'b0;
      end else begin
        if (chk_rdy && in_valid)
          check("in_ready", 512'(in_ready), 512'((acc_cnt - dlv_cnt < 2) || out_ready));
        if (chk_rdy && in_valid && !in_ready) stall_seen = 1'b1;
        if (stall_q) check("stall_hold", 512'({out_valid, out_data, out_keep, out_last}), 512'({1'b1, held}));
        stall_q = out_valid && !out_ready;
        held = {out_data, out_keep, out_last};
        if (done) done_cnt++;
        if (in_valid && in_ready) acc_cnt++;
        if (out_valid && out_ready) begin
          dlv_cnt++;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat: got unexpected %0h expected none", out_data);
          end else begin
            b = sb.pop_front();
            check("beat", 512'({out_data, out_keep, out_last}), 512'(b));
            check("done_with_last", 512'(done), 512'(b.l));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [0:7][7:0] xa, pa, ra;
    int d0, lat, dl0;

    tbl[0] = mk(0, 0, 127, 16'h0010, 16'hFFFF, v8(-5, 0, 7, -128, 127, 1, -1, 64),     v8(0, 0, 7, 0, 127, 1, 0, 64));
    tbl[1] = mk(2, 2, 127, 16'h0010, 16'h0F0F, v8(-7, -1, -128, 127, 0, 5, -4, -8),    v8(-2, -1, -32, 127, 0, 5, -1, -2));
    tbl[2] = mk(1, 0, 6,   16'h0010, 16'hFFFF, v8(9, -3, 6, 5, 127, -128, 0, 7),       v8(6, 0, 6, 5, 6, 0, 0, 6));
    tbl[3] = mk(1, 0, -4,  16'h0010, 16'hFFFF, v8(9, -3, 0, 5, 127, -128, 1, -1),      v8(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[4] = mk(3, 0, 127, 16'h0010, 16'hFFFF, v8(100, -2, -7, -128, -64, 0, 127, 32), v8(100, -2, -5, -128, -64, 0, 127, 32));
    tbl[5] = mk(3, 0, 127, 16'h7FFF, 16'hFFFF, v8(127, 100, 96, -2, 0, 1, -1, -100),   v8(127, 127, 127, -2, 0, 1, -2, -100));
    tbl[6] = mk(3, 0, 127, 16'h8000, 16'h7FFE, v8(100, 127, 96, 0, -2, 1, -128, 64),   v8(-128, -128, -128, 0, -2, 1, -128, 64));
    tbl[7] = mk(5, 0, 127, 16'h0010, 16'h00FF, v8(-5, 0, 7, -128, 127, 1, -1, 64),     v8(-5, 0, 7, -128, 127, 1, -1, 64));

    rst_b = 1'b0; start = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out", 512'({out_valid, out_last, out_data, out_keep}), 512'(0));
    check("rst_ctl", 512'({busy, done, in_ready}), 512'(0));
    tick();
    rst_b = 1'b1;
    tick();

    csr_write(BASE + 6'd8, {32'h0, 16'hFFFF, 16'h0008});

    for (int r = 0; r < 8; r++) begin
      csr_write(BASE, cfg_word(tbl[r].mode, tbl[r].leaky, tbl[r].clamp));
      csr_write(BASE + 6'd4, {32'h0, 16'h0000, tbl[r].slope3});
      d0 = done_cnt;
      pulse_start();
      send_beat(lanes_of(tbl[r].x, 16'hFFFF), tbl[r].keep, 1'b1, lanes_of(tbl[r].e, tbl[r].keep));
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("latency", 512'(lat), 512'(2));
      wait_idle();
      check("done_once", 512'(done_cnt - d0), 512'(1));
    end

    // Backpressure: bypass job of 5 beats with out_ready cycling 1,0,0,1.
    csr_write(BASE, cfg_word(3'd5, 4'd0, 8'd127));
    d0 = done_cnt;
    dl0 = dlv_cnt;
    pulse_start();
    chk_rdy = 1'b1;
    fork
      begin
        for (int b = 0; b < 5; b++) send_beat(bp_data(b), 16'hFFFF, b == 4, bp_data(b));
      end
      begin
        int n = 0;
        while (dlv_cnt < dl0 + 5 && n < 200) begin
          out_ready = (n % 4 == 0) || (n % 4 == 3);
          tick();
          n++;
        end
        if (n >= 200) fail("bp_drain");
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk_rdy = 1'b0;
    check("bp_stall_seen", 512'(stall_seen), 512'(1));
    check("bp_count", 512'(dlv_cnt - dl0), 512'(5));
    check("bp_done", 512'(done_cnt - d0), 512'(1));

    // Shadow write and start during a PWL job must not touch the active set.
    xa = v8(100, -2, -7, -128, -64, 0, 127, 32);
    pa = v8(100, -2, -5, -128, -64, 0, 127, 32);
    ra = v8(100, 0, 0, 0, 0, 0, 127, 32);
    csr_write(BASE, cfg_word(3'd3, 4'd0, 8'd127));
    csr_write(BASE + 6'd4, {32'h0, 16'h0000, 16'h0010});
    pulse_start();
    send_beat(lanes_of(xa, 16'hFFFF), 16'hFFFF, 1'b0, lanes_of(pa, 16'hFFFF));
    csr_write(BASE, cfg_word(3'd0, 4'd0, 8'd127));
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 512'(busy), 512'(1));
    @(posedge clk); #1;
    send_beat(lanes_of(xa, 16'hFFFF), 16'hFFFF, 1'b1, lanes_of(pa, 16'hFFFF));
    wait_idle();
    pulse_start();
    send_beat(lanes_of(xa, 16'hFFFF), 16'hFFFF, 1'b1, lanes_of(ra, 16'hFFFF));
    wait_idle();

    // Async reset with two beats in flight.
    csr_write(BASE, cfg_word(3'd3, 4'd0, 8'd127));
    csr_write(BASE + 6'd4, {32'h0, 16'h0000, 16'h7FFF});
    pulse_start();
    out_ready = 1'b0;
    send_beat(lanes_of(tbl[5].x, 16'hFFFF), 16'hFFFF, 1'b0, lanes_of(tbl[5].e, 16'hFFFF));
    send_beat(lanes_of(tbl[4].x, 16'hFFFF), 16'hFFFF, 1'b0, lanes_of(tbl[5].e, 16'hFFFF));
    @(negedge clk);
    check("full_valid", 512'(out_valid), 512'(1));
    check("full_ready", 512'(in_ready), 512'(0));
    d0 = done_cnt;
    rst_b = 1'b0;
    #1;
    check("rst_async", 512'({out_valid, busy, in_ready}), 512'(0));
    sb.delete();
    acc_cnt = 0;
    dlv_cnt = 0;
    @(posedge clk); #1;
    tick();
    rst_b = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    check("no_done_on_rst", 512'(done_cnt - d0), 512'(0));

    csr_write(6'h2F, 64'h0000_0000_7FFF_0003);
    csr_write(6'h39, 64'h0000_0000_7FFF_7FFF);
    csr_write(BASE, cfg_word(3'd3, 4'd0, 8'd127));
    xa = v8(-7, 100, 127, -2, -128, -64, 1, -1);
    pulse_start();
    send_beat(lanes_of(xa, 16'hFFFF), 16'hFFFF, 1'b1, lanes_of(xa, 16'hFFFF));
    wait_idle();
    check("rst_done", 512'(done_cnt - d0), 512'(1));
    check("sb_empty", 512'(sb.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/act_core_pwl.md
Name: act_core_pwl

Overview:
Second-generation streaming activation engine for INT-N tensors, placed on the AXI-stream path after the accumulator/requant stage. Supports ReLU, clamped ReLU, LeakyReLU and a programmable 8-segment piecewise-linear (PWL) function for SiLU, GELU and sigmoid-class curves. Uses a 2-stage valid/ready pipeline with per-lane keep masking, and latches configuration at job start (shadow/active registers), so CSR writes during a job never corrupt in-flight beats.

Parameters:
DATA_WIDTH, 8, element width in bits (signed, two's complement), range 4..16
LANES, 16, elements per beat; stream width = LANES*DATA_WIDTH
FRAC, 4, fractional bits of PWL slope
CFG_BASE, 6'h30, CSR base address

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous reset, active-low
start  in  1  job start pulse
cfg_wr_en  in  1  CSR write strobe
cfg_addr  in  6  CSR address
cfg_wdata  in  64  CSR write data
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  LANES*DATA_WIDTH  packed elements, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
in_keep  in  LANES  per-lane valid mask
in_last  in  1  final beat of job
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  LANES*DATA_WIDTH  activated elements
out_keep  out  LANES  keep, passed through
out_last  out  1  final beat, passed through
busy  out  1  job active
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: rst_b is asynchronous, active-low; clock is clk. On reset: out_valid=0, out_last=0, out_data=0, out_keep=0, busy=0, done=0; both pipeline stages are invalid; shadow and active mode=0, leaky_shift=0, clamp_max=+max; PWL slope[s]=1<<FRAC and offset[s]=0 (identity).
- Reset mid-job: in-flight beats are dropped. No done pulse is generated.
- CSRs (write-only shadows):
  - CFG_BASE+0: mode[2:0] (0=ReLU, 1=clamped ReLU, 2=LeakyReLU, 3=PWL, 4-7=bypass); leaky_shift[11:8]; clamp_max[16 +: DATA_WIDTH].
  - CFG_BASE+1+s, s=0..7: slope[15:0] signed; offset[31:16] signed.
  - Writes to other addresses are ignored.
- Job control:
  - start while !busy copies all shadows to active and sets busy on the next edge.
  - start while busy is ignored.
  - in_ready=0 whenever !busy.
- Pipeline:
  - s1 registers input and keep; s2 is the output register.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = busy && s1_adv.
  - Latency is 2 cycles from acceptance to out_valid with out_ready=1; throughput is 1 beat/cycle.
  - Stalled out_data and out_last are held stable.
  - A full pipeline with out_ready=0 holds 2 beats, and in_ready drops.
- Per-lane function, x signed DATA_WIDTH. Results saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - ReLU: max(x,0).
  - Clamped ReLU: min(max(x,0), clamp_max). A negative clamp_max yields 0.
  - LeakyReLU: x>=0 ? x : x>>>leaky_shift (arithmetic shift, floor).
  - PWL: s = x[DATA_WIDTH-1 -: 3] as unsigned segment index; y = sat(((x*slope[s]) >>> FRAC) + offset[s]). Compute in 32-bit signed.
  - Bypass: y = x.
  - Lanes with keep=0 output 0.
- Arithmetic is split: s1 computes the product, s2 computes shift/add/saturate.
- Completion:
  - When out_valid && out_ready && out_last: done=1 for one cycle and busy=0 on the same edge.
  - A start in that same cycle is ignored; start is honoured from the next cycle.
- CSR writes while busy update shadows only. The active set is unchanged until the next start.

Test Plan:
1. ReLU, DATA_WIDTH=8, start, single beat lanes {-5,0,7,-128,127,...}, in_last=1 -> out {0,0,7,0,127,...}, out_valid exactly 2 cycles after acceptance, done pulse coincident with output handshake, busy falls.
2. LeakyReLU shift=2, clamped ReLU clamp_max=6 -> x=-7 gives -2 (floor); clamp case x=9 gives 6, x=-3 gives 0.
3. PWL, segment 3 slope=0x0010 offset=0, segment 7 slope=0x0008 offset=-1 -> x=100 gives 100; x=-2 gives (-2*8>>>4)-1=-2; slope=0x7FFF with x=127 saturates to 127.
4. Backpressure: 5-beat job, out_ready toggled 1,0,0,1 -> in_ready falls once 2 beats are held; no beat lost or duplicated; out_data stable while stalled.
5. Mid-job shadow write of mode=0 during a PWL job -> remaining beats still use PWL; next start uses ReLU.
6. Async reset asserted with 2 beats in flight -> out_valid=0 and busy=0 immediately; no done pulse; identity PWL afterwards; a start while busy is ignored.
